rnn_seq_core: RTL and testbench
===============================

Name: rnn_seq_core

Overview:
Parametrised Elman RNN cell with a dense scalar output head, for the HPS–FPGA slave bus. It is the next generation of the fixed-size RNN accelerator. Each start command runs one time step: h' = act(b + x·Wx + h·Wh), then y = db + h'·d. Dimensions, fixed-point format and activation are parameters. New over the previous generation: single time-multiplexed MAC with a deterministic latency, double-buffered hidden state, per-step output, saturating arithmetic, and a sticky protocol-error flag.

Parameters:
EMB_LEN, 4, input vector length (1..256)
HID_LEN, 32, hidden units (1..256)
FRAC_BITS, 8, fractional bits of 16-bit signed fixed point (Q7.8 default)
ACC_W, 32, accumulator width
ACT_MODE, 0, 0 = hard tanh (clamp to ±2^FRAC_BITS), 1 = identity

Ports:
clk  in  1  clock
rst  in  1  reset
read  in  1  bus read strobe
write  in  1  bus write strobe
addr  in  3  register select
data_in  in  32  write data; [15:0] value, [23:16] index/column, [31:24] row
data_out  out  32  read data, combinational

Interface decision: one clock; reset is asynchronous and active-high (rst).

Behaviour:
- Reset clears all parameter arrays, both hidden banks, accumulator, result, valid, error and bank pointer, and sets state IDLE. data_out = 0.
- Reset asserted mid-step aborts the step with no partial update surviving.
- Write map, effective only in IDLE:
  - addr1: x[idx] = value
  - addr2: Wx[row][col]
  - addr3: Wh[row = source j][col = dest i]
  - addr4: b[idx]
  - addr5: d[idx]
  - addr6: db = value
  - addr7: zero both hidden banks in one cycle
  - addr0: start; data_in[1] = 1 zeroes the hidden state before the step starts.
- Error conditions: any index ≥ its length, or any write other than addr0 while busy. The write is ignored and error is set (sticky). A start while busy is also ignored and sets error.
- Read map:
  - addr0: {29'b0, error, busy, valid}; the read clears error.
  - addr7: result sign-extended to 32 bits; the read clears valid.
  - addr4: {31'b0, result ≥ 0}
  - addr1: 32'h0000_0391
  - others: 0
  - data_out = 0 when read is low.
- States: IDLE, ROW, MAC_X, MAC_H, ACT, SWAP, DENSE, OUT.
  - ROW: acc = sign-extended b[i].
  - MAC_X, EMB_LEN cycles: acc += (x[k]*Wx[k][i]) >>> FRAC_BITS.
  - MAC_H, HID_LEN cycles: acc += (h_cur[j]*Wh[j][i]) >>> FRAC_BITS.
  - ACT: h_next[i] = act(sat16(acc)). Then i++ → ROW, or → SWAP after i = HID_LEN-1.
  - SWAP: toggle bank pointer, acc = db.
  - DENSE, HID_LEN cycles: acc += (h[j]*d[j]) >>> FRAC_BITS.
  - OUT: result = sat16(acc), valid = 1 → IDLE.
- busy = (state != IDLE). Starting a step clears valid.
- Latency: valid rises LAT = HID_LEN*(EMB_LEN+HID_LEN+2) + HID_LEN + 2 edges after the edge sampling the start write. LAT = 1250 at defaults.
- Arithmetic:
  - Products are 32-bit signed, arithmetic right shift (floor).
  - The accumulator wraps at ACC_W.
  - sat16 clamps to [-32768, 32767].
  - Hard tanh clamps to [-2^FRAC_BITS, 2^FRAC_BITS].
- h_cur is never modified during a step; the new state becomes visible only at SWAP.
- x is unchanged by a step, so a sequence is run as: load x, start, poll valid, read result, repeat.

Decomposition:
- rnn_pkg holds:
  - state_t enum
  - address constants ADDR_START..ADDR_RESULT
  - ID constant 32'h0000_0391
  - sat16 and hardtanh functions
- One sub-module, fx_mac: clear/load/accumulate control, 16x16 signed multiply, shift, ACC_W accumulator, saturated 16-bit output.

Test Plan:
- Use EMB_LEN=2, HID_LEN=2, FRAC_BITS=8 unless stated; LAT = 16.
- Identity step: Wx = I (256 on the diagonal), Wh = 0, b = 0, d = {256,256}, db = 0, x = {128,64}, start → valid exactly 16 edges later; result = 192; h = {128,64}.
- Recurrence and bank isolation: Wh = I, Wx = 0, b = {256,0}, hidden cleared; step1 → h = {256,0}, result = 256. Step2 → hard tanh clamps h0 = 256, result = 256. Step2 with Wh[0][1] = 256 gives h1 = 256 from the old h, not the partially updated h.
- Saturation: ACT_MODE=1, x = {32767,32767}, Wx all 32767, d = {32767,32767} → h = 32767, result = 32767; negated d → result = -32768.
- Errors: write addr3 with row 5 → parameter unchanged, status = 3'b100; status read then reads 0. A write during busy is ignored and sets error; a start while busy is ignored.
- Clear: data_in[1] start after a nonzero h → same result as a fresh reset-loaded step. An addr7 write zeroes h, visible via the next identity step.
- Reset mid-step: assert rst at cycle 7 of a step → status 0, result 0; the next full step matches the golden model.

Source files
------------

// File: rtl/rnn_pkg.sv
// Shared types, register map and fixed-point helpers for the Elman RNN core.
package rnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_MAC_X, S_MAC_H, S_ACT, S_SWAP, S_DENSE, S_OUT
  } state_t;

  localparam logic [2:0] ADDR_START  = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_X      = 3'd1;
  localparam logic [2:0] ADDR_ID     = 3'd1;
  localparam logic [2:0] ADDR_WX     = 3'd2;
  localparam logic [2:0] ADDR_WH     = 3'd3;
  localparam logic [2:0] ADDR_B      = 3'd4;
  localparam logic [2:0] ADDR_SIGN   = 3'd4;
  localparam logic [2:0] ADDR_D      = 3'd5;
  localparam logic [2:0] ADDR_DB     = 3'd6;
  localparam logic [2:0] ADDR_CLEAR  = 3'd7;
  localparam logic [2:0] ADDR_RESULT = 3'd7;

  localparam logic [31:0] CORE_ID = 32'h0000_0391;

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7fff;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] hardtanh(input logic signed [15:0] v,
                                                  input int unsigned frac);
    logic signed [31:0] lim;
    logic signed [31:0] w;
    lim = 32'sd1 <<< frac;
    w   = 32'(v);
    if (w > lim)       return 16'(lim);
    else if (w < -lim) return 16'(-lim);
    else               return v;
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Time-multiplexed fixed-point MAC: 16x16 signed product, floor shift, wrapping accumulator.
module fx_mac
  import rnn_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               accum,
  input  logic signed [15:0] load_val,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] acc_sat
);

  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      prod;
  logic signed [31:0]      term;

  assign prod = 32'(a) * 32'(b);
  assign term = prod >>> FRAC_BITS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clr)   acc <= '0;
    else if (load)  acc <= ACC_W'(load_val);
    else if (accum) acc <= acc + ACC_W'(term);
  end

  assign acc_sat = sat16(64'(acc));

endmodule

// File: rtl/rnn_seq_core.sv
// Elman RNN cell with scalar dense head behind a simple register bus; one time step per start.
module rnn_seq_core
  import rnn_pkg::*;
#(
  parameter int unsigned EMB_LEN   = 4,
  parameter int unsigned HID_LEN   = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned ACT_MODE  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int unsigned EW = (EMB_LEN > 1) ? $clog2(EMB_LEN) : 1;
  localparam int unsigned HW = (HID_LEN > 1) ? $clog2(HID_LEN) : 1;
  localparam int unsigned KW = (EW > HW) ? EW : HW;

  logic signed [15:0] x_mem  [EMB_LEN];
  logic signed [15:0] wx_mem [EMB_LEN][HID_LEN];
  logic signed [15:0] wh_mem [HID_LEN][HID_LEN];
  logic signed [15:0] b_mem  [HID_LEN];
  logic signed [15:0] d_mem  [HID_LEN];
  logic signed [15:0] h_mem  [2][HID_LEN];
  logic signed [15:0] db;
  logic signed [15:0] result;
  logic               bank;
  logic               valid;
  logic               error;
  state_t             state;
  logic [HW-1:0]      i_cnt;
  logic [KW-1:0]      k_cnt;

  logic [7:0]         f_row;
  logic [7:0]         f_idx;
  logic signed [15:0] f_val;
  logic               emb_row_ok, emb_idx_ok, hid_row_ok, hid_idx_ok;
  logic               busy, zero_h;
  logic               mac_clr, mac_load, mac_acc;
  logic signed [15:0] load_val, op_a, op_b, mac_sat, act_val;

  assign f_row      = data_in[31:24];
  assign f_idx      = data_in[23:16];
  assign f_val      = data_in[15:0];
  assign emb_row_ok = {1'b0, f_row} < 9'(EMB_LEN);
  assign emb_idx_ok = {1'b0, f_idx} < 9'(EMB_LEN);
  assign hid_row_ok = {1'b0, f_row} < 9'(HID_LEN);
  assign hid_idx_ok = {1'b0, f_idx} < 9'(HID_LEN);
  assign busy       = (state != S_IDLE);
  assign zero_h     = write && !busy &&
                      ((addr == ADDR_CLEAR) || (addr == ADDR_START && data_in[1]));
  assign act_val    = (ACT_MODE == 1) ? mac_sat : hardtanh(mac_sat, FRAC_BITS);

  // MAC operand routing; h_mem[bank] is the current state, h_mem[~bank] the one being built.
  always_comb begin
    mac_clr  = 1'b0;
    mac_load = 1'b0;
    mac_acc  = 1'b0;
    load_val = '0;
    op_a     = '0;
    op_b     = '0;
    unique case (state)
      S_IDLE:  mac_clr = write && (addr == ADDR_START);
      S_ROW:   begin mac_load = 1'b1; load_val = b_mem[i_cnt]; end
      S_MAC_X: begin
        mac_acc = 1'b1;
        op_a    = x_mem[k_cnt[EW-1:0]];
        op_b    = wx_mem[k_cnt[EW-1:0]][i_cnt];
      end
      S_MAC_H: begin
        mac_acc = 1'b1;
        op_a    = h_mem[bank][k_cnt[HW-1:0]];
        op_b    = wh_mem[k_cnt[HW-1:0]][i_cnt];
      end
      S_SWAP:  begin mac_load = 1'b1; load_val = db; end
      S_DENSE: begin
        mac_acc = 1'b1;
        op_a    = h_mem[bank][k_cnt[HW-1:0]];
        op_b    = d_mem[k_cnt[HW-1:0]];
      end
      default: ;
    endcase
  end

  fx_mac #(.FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .load     (mac_load),
    .accum    (mac_acc),
    .load_val (load_val),
    .a        (op_a),
    .b        (op_b),
    .acc_sat  (mac_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < EMB_LEN; r++) begin
        x_mem[EW'(r)] <= '0;
        for (int unsigned c = 0; c < HID_LEN; c++) wx_mem[EW'(r)][HW'(c)] <= '0;
      end
      for (int unsigned r = 0; r < HID_LEN; r++) begin
        b_mem[HW'(r)]    <= '0;
        d_mem[HW'(r)]    <= '0;
        h_mem[0][HW'(r)] <= '0;
        h_mem[1][HW'(r)] <= '0;
        for (int unsigned c = 0; c < HID_LEN; c++) wh_mem[HW'(r)][HW'(c)] <= '0;
      end
      db     <= '0;
      result <= '0;
      bank   <= 1'b0;
      valid  <= 1'b0;
      error  <= 1'b0;
      i_cnt  <= '0;
      k_cnt  <= '0;
      state  <= S_IDLE;
    end else begin
      if (read && addr == ADDR_STATUS) error <= 1'b0;
      if (read && addr == ADDR_RESULT) valid <= 1'b0;

      unique case (state)
        S_IDLE: if (write) begin
          unique case (addr)
            ADDR_START: begin
              valid <= 1'b0;
              i_cnt <= '0;
              k_cnt <= '0;
              state <= S_ROW;
            end
            ADDR_X:  if (emb_idx_ok) x_mem[f_idx[EW-1:0]] <= f_val;
                     else error <= 1'b1;
            ADDR_WX: if (emb_row_ok && hid_idx_ok) wx_mem[f_row[EW-1:0]][f_idx[HW-1:0]] <= f_val;
                     else error <= 1'b1;
            ADDR_WH: if (hid_row_ok && hid_idx_ok) wh_mem[f_row[HW-1:0]][f_idx[HW-1:0]] <= f_val;
                     else error <= 1'b1;
            ADDR_B:  if (hid_idx_ok) b_mem[f_idx[HW-1:0]] <= f_val;
                     else error <= 1'b1;
            ADDR_D:  if (hid_idx_ok) d_mem[f_idx[HW-1:0]] <= f_val;
                     else error <= 1'b1;
            ADDR_DB: db <= f_val;
            default: ;
          endcase
        end
        S_ROW: begin
          k_cnt <= '0;
          state <= S_MAC_X;
        end
        S_MAC_X: begin
          if (k_cnt == KW'(EMB_LEN - 1)) begin
            k_cnt <= '0;
            state <= S_MAC_H;
          end else k_cnt <= k_cnt + 1'b1;
        end
        S_MAC_H: begin
          if (k_cnt == KW'(HID_LEN - 1)) state <= S_ACT;
          else k_cnt <= k_cnt + 1'b1;
        end
        S_ACT: begin
          h_mem[~bank][i_cnt] <= act_val;
          if (i_cnt == HW'(HID_LEN - 1)) state <= S_SWAP;
          else begin
            i_cnt <= i_cnt + 1'b1;
            state <= S_ROW;
          end
        end
        S_SWAP: begin
          bank  <= ~bank;
          k_cnt <= '0;
          state <= S_DENSE;
        end
        S_DENSE: begin
          if (k_cnt == KW'(HID_LEN - 1)) state <= S_OUT;
          else k_cnt <= k_cnt + 1'b1;
        end
        S_OUT: begin
          result <= mac_sat;
          valid  <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (zero_h) begin
        for (int unsigned j = 0; j < HID_LEN; j++) begin
          h_mem[0][HW'(j)] <= '0;
          h_mem[1][HW'(j)] <= '0;
        end
      end
      if (write && busy) error <= 1'b1;
    end
  end

  always_comb begin
    data_out = '0;
    if (read) begin
      unique case (addr)
        ADDR_STATUS: data_out = {29'b0, error, busy, valid};
        ADDR_ID:     data_out = CORE_ID;
        ADDR_SIGN:   data_out = {31'b0, ~result[15]};
        ADDR_RESULT: data_out = 32'(result);
        default:     data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_seq_core.sv
// Bench for rnn_seq_core: hard-tanh and identity instances share one bus, checked against a step model.
module tb_rnn_seq_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out0, data_out1;

  always #5 clk = ~clk;

  rnn_seq_core #(.EMB_LEN(2), .HID_LEN(2), .FRAC_BITS(8), .ACC_W(32), .ACT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out0)
  );
  rnn_seq_core #(.EMB_LEN(2), .HID_LEN(2), .FRAC_BITS(8), .ACC_W(32), .ACT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out1)
  );

  typedef struct { logic [2:0] a; logic [31:0] exp; } rvec_t;
  typedef struct { int x0; int x1; int r0; int r1; } svec_t;
  typedef struct { int r0; int r1; } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  int mx[2];
  int mwx[2][2];
  int mwh[2][2];
  int mb[2];
  int md[2];
  int mdb;
  int mh[2][2];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int row, input int idx, input int val);
    return {row[7:0], idx[7:0], val[15:0]};
  endfunction

  function automatic int msat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int mact(input int v, input int m);
    if (m == 1) return v;
    if (v > 256) return 256;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; mb[i] = 0; md[i] = 0; mh[0][i] = 0; mh[1][i] = 0;
      for (int j = 0; j < 2; j++) begin mwx[i][j] = 0; mwh[i][j] = 0; end
    end
    mdb = 0;
  endfunction

  function automatic void model_zero_h();
    for (int i = 0; i < 2; i++) begin mh[0][i] = 0; mh[1][i] = 0; end
  endfunction

  function automatic int model_step(input int m);
    int hn[2];
    int acc;
    for (int i = 0; i < 2; i++) begin
      acc = mb[i];
      for (int k = 0; k < 2; k++) acc += (mx[k] * mwx[k][i]) >>> 8;
      for (int j = 0; j < 2; j++) acc += (mh[m][j] * mwh[j][i]) >>> 8;
      hn[i] = mact(msat(acc), m);
    end
    for (int i = 0; i < 2; i++) mh[m][i] = hn[i];
    acc = mdb;
    for (int j = 0; j < 2; j++) acc += (mh[m][j] * md[j]) >>> 8;
    return msat(acc);
  endfunction

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    write = 1'b1; addr = a; data_in = v;
    @(posedge clk); #1;
    write = 1'b0; data_in = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r1);
    read = 1'b1; addr = a;
    #1;
    r0 = data_out0; r1 = data_out1;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] a, input int row, input int idx, input int val);
    wr(a, enc(row, idx, val));
    case (a)
      3'd1: mx[idx] = val;
      3'd2: mwx[row][idx] = val;
      3'd3: mwh[row][idx] = val;
      3'd4: mb[idx] = val;
      3'd5: md[idx] = val;
      3'd6: mdb = val;
      default: ;
    endcase
  endtask

  task automatic start_step(input bit clr);
    exp_t e;
    if (clr) model_zero_h();
    e.r0 = model_step(0);
    e.r1 = model_step(1);
    sbq.push_back(e);
    wr(3'd0, clr ? 32'd2 : 32'd0);
  endtask

  task automatic status_chk(input string nm, input int exp);
    logic [31:0] r0, r1;
    rd(3'd0, r0, r1);
    check({nm, "_m0"}, int'(r0), exp);
    check({nm, "_m1"}, int'(r1), exp);
  endtask

  task automatic finish_step(input int lat_exp);
    logic [31:0] r0, r1;
    exp_t e;
    int n;
    bit got;
    n = 0; got = 1'b0;
    read = 1'b1; addr = 3'd0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (data_out0[0]) got = 1'b1;
    end
    if (!got) check("valid_timeout", n, lat_exp);
    else begin
      check("status_m1_at_valid", int'(data_out1), 1);
      if (lat_exp > 0) check("latency", n, lat_exp);
    end
    read = 1'b0;
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      rd(3'd7, r0, r1);
      check("result_m0", $signed(r0), e.r0);
      check("result_m1", $signed(r1), e.r1);
      status_chk("status_after_read", 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rvec_t rtab[8];
    svec_t stab[5];
    logic [31:0] r0, r1;

    rtab[0] = '{3'd0, 32'h0};
    rtab[1] = '{3'd1, 32'h0000_0391};
    rtab[2] = '{3'd2, 32'h0};
    rtab[3] = '{3'd3, 32'h0};
    rtab[4] = '{3'd4, 32'h1};
    rtab[5] = '{3'd5, 32'h0};
    rtab[6] = '{3'd6, 32'h0};
    rtab[7] = '{3'd7, 32'h0};

    stab[0] = '{128, 64, 192, 192};
    stab[1] = '{300, -50, 206, 250};
    stab[2] = '{-400, -400, -512, -800};
    stab[3] = '{20000, 20000, 512, 32767};
    stab[4] = '{-1, 0, -1, -1};

    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      rd(rtab[t].a, r0, r1);
      check($sformatf("reset_rd%0d_m0", t), int'(r0), int'(rtab[t].exp));
      check($sformatf("reset_rd%0d_m1", t), int'(r1), int'(rtab[t].exp));
    end
    read = 1'b0; addr = 3'd1;
    #1 check("read_low", int'(data_out0), 0);

    // identity projection, table driven
    cfg(3'd2, 0, 0, 256); cfg(3'd2, 1, 1, 256);
    cfg(3'd5, 0, 0, 256); cfg(3'd5, 0, 1, 256);
    for (int t = 0; t < 5; t++) begin
      exp_t e;
      cfg(3'd1, 0, 0, stab[t].x0);
      cfg(3'd1, 0, 1, stab[t].x1);
      void'(model_step(0));
      void'(model_step(1));
      e.r0 = stab[t].r0; e.r1 = stab[t].r1;
      sbq.push_back(e);
      wr(3'd0, 32'd0);
      finish_step(16);
      rd(3'd4, r0, r1);
      check("sign_m0", int'(r0), (stab[t].r0 >= 0) ? 1 : 0);
      check("sign_m1", int'(r1), (stab[t].r1 >= 0) ? 1 : 0);
    end

    // recurrence through Wh; h1 must see the old h0
    cfg(3'd2, 0, 0, 0); cfg(3'd2, 1, 1, 0);
    cfg(3'd3, 0, 0, 256); cfg(3'd3, 0, 1, 256);
    cfg(3'd4, 0, 0, 128);
    wr(3'd7, 32'd0); model_zero_h();
    for (int s = 0; s < 3; s++) begin
      start_step(1'b0);
      finish_step(16);
    end

    // clear via start flag and via addr7
    start_step(1'b1); finish_step(16);
    start_step(1'b0); finish_step(16);
    wr(3'd7, 32'd0); model_zero_h();
    start_step(1'b0); finish_step(16);

    // protocol errors in IDLE
    wr(3'd3, enc(5, 1, 256));
    status_chk("err_bad_row", 4);
    status_chk("err_cleared", 0);
    wr(3'd1, enc(0, 2, 77));
    status_chk("err_bad_idx", 4);
    start_step(1'b1); finish_step(16);

    // writes while busy are dropped
    start_step(1'b0);
    wr(3'd5, enc(0, 0, 999));
    wr(3'd0, 32'd0);
    status_chk("err_busy", 6);
    finish_step(13);

    // reset in the middle of a step
    start_step(1'b0);
    sbq.delete();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    status_chk("midreset_status", 0);
    rd(3'd7, r0, r1);
    check("midreset_result_m0", int'(r0), 0);
    check("midreset_result_m1", int'(r1), 0);
    cfg(3'd2, 0, 0, 256); cfg(3'd2, 1, 1, 256);
    cfg(3'd5, 0, 0, 256); cfg(3'd5, 0, 1, 256);
    cfg(3'd1, 0, 0, 128); cfg(3'd1, 0, 1, 64);
    start_step(1'b0); finish_step(16);

    // saturation at ACT and OUT
    cfg(3'd1, 0, 0, 32767); cfg(3'd1, 0, 1, 32767);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) cfg(3'd2, r, c, 32767);
    cfg(3'd5, 0, 0, 32767); cfg(3'd5, 0, 1, 32767);
    start_step(1'b0); finish_step(16);
    cfg(3'd5, 0, 0, -32767); cfg(3'd5, 0, 1, -32767);
    start_step(1'b0); finish_step(16);
    rd(3'd4, r0, r1);
    check("sign_neg_m0", int'(r0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
